// File: rtl/mano_ctrl_seq_if.sv
// Control bundle between the Mano accumulator datapath and its sequencer.
// START is a one-cycle request pulse from the datapath side. It is sampled only while the sequencer is halted. There is no ready/ack back.
interface mano_ctrl_seq_if #(
  parameter int DATA_W = 8
);
  logic              START;
  logic [DATA_W-1:0] IR;
  logic              AC_ZERO;
  logic              AC_MSB;
  logic [1:0]        SC;
  logic              HALTED;
  logic              AC_LD;
  logic              AC_INC;
  logic              AC_CLR;
  logic              PC_LD;
  logic              PC_INC;
  logic              AR_LD;
  logic              IR_LD;
  logic              MEM_RD;
  logic              MEM_WR;
  logic [2:0]        BUS_SEL;
  logic [1:0]        ALU_OP;

  modport master (
    output START, IR, AC_ZERO, AC_MSB,
    input  SC, HALTED, AC_LD, AC_INC, AC_CLR, PC_LD, PC_INC,
           AR_LD, IR_LD, MEM_RD, MEM_WR, BUS_SEL, ALU_OP
  );

  modport slave (
    input  START, IR, AC_ZERO, AC_MSB,
    output SC, HALTED, AC_LD, AC_INC, AC_CLR, PC_LD, PC_INC,
           AR_LD, IR_LD, MEM_RD, MEM_WR, BUS_SEL, ALU_OP
  );
endinterface

// File: rtl/mano_ctrl_seq.sv
// Fetch/decode/execute sequencer for the 8-bit Mano accumulator machine.
// The FSM state and the step counter are registered. The strobes are decoded combinationally from them.
module mano_ctrl_seq #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter bit START_AUTO = 1'b0
) (
  input  logic               CLK,
  input  logic               CLR,
  mano_ctrl_seq_if.slave     bus,
  output logic               dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_REG = 3'd5;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_MEM  = 3'd2;
  localparam logic [2:0] BUS_IR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;

  state_t      state_q, state_d;
  logic [1:0]  sc_q, sc_d;
  logic        auto_q, auto_d;

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] fld;
  logic              hlt;

  assign opcode = bus.IR[DATA_W-1 -: 3];
  assign fld    = bus.IR[ADDR_W-1:0];
  assign hlt    = (opcode == OP_REG) && fld[4];

  // auto_q causes a single automatic start after reset. HLT never sets it, so a halted machine waits for START.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    auto_d  = auto_q;
    case (state_q)
      S_IDLE: begin
        sc_d = 2'd0;
        if (bus.START || auto_q) begin
          state_d = S_RUN;
          auto_d  = 1'b0;
        end
      end
      S_RUN: begin
        sc_d = sc_q + 2'd1;
        if (sc_q == 2'd3 && hlt) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sc_d    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_IDLE;
      sc_q    <= 2'd0;
      auto_q  <= START_AUTO;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      auto_q  <= auto_d;
    end
  end

  assign bus.SC      = sc_q;
  assign bus.HALTED  = (state_q == S_IDLE);
  assign dbg_state_o = state_q;

  // CLR gates every strobe, so a reset in the middle of an instruction does not commit a partial write.
  always_comb begin
    bus.AC_LD   = 1'b0;
    bus.AC_INC  = 1'b0;
    bus.AC_CLR  = 1'b0;
    bus.PC_LD   = 1'b0;
    bus.PC_INC  = 1'b0;
    bus.AR_LD   = 1'b0;
    bus.IR_LD   = 1'b0;
    bus.MEM_RD  = 1'b0;
    bus.MEM_WR  = 1'b0;
    bus.BUS_SEL = BUS_NONE;
    bus.ALU_OP  = 2'b00;
    if (!CLR && state_q == S_RUN) begin
      case (sc_q)
        2'd0: begin
          bus.BUS_SEL = BUS_PC;
          bus.AR_LD   = 1'b1;
        end
        2'd1: begin
          bus.MEM_RD  = 1'b1;
          bus.BUS_SEL = BUS_MEM;
          bus.IR_LD   = 1'b1;
          bus.PC_INC  = 1'b1;
        end
        2'd2: begin
          bus.BUS_SEL = BUS_IR;
          bus.AR_LD   = 1'b1;
        end
        default: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA: begin
              bus.MEM_RD  = 1'b1;
              bus.BUS_SEL = BUS_MEM;
              bus.AC_LD   = 1'b1;
              bus.ALU_OP  = (opcode == OP_AND) ? 2'b01 :
                            (opcode == OP_ADD) ? 2'b10 : 2'b00;
            end
            OP_STA: begin
              bus.BUS_SEL = BUS_AC;
              bus.MEM_WR  = 1'b1;
            end
            OP_BUN: begin
              bus.BUS_SEL = BUS_IR;
              bus.PC_LD   = 1'b1;
            end
            OP_REG: begin
              // The skip tests read the flags as they are before this step's AC update. CLA takes priority over INC.
              bus.AC_CLR = fld[0];
              bus.AC_INC = fld[1] & ~fld[0];
              bus.PC_INC = (fld[2] & bus.AC_ZERO) | (fld[3] & ~bus.AC_MSB);
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule
